// File: rtl/ahb_reg_slave.sv
// AHB-Lite register slave: CTRL (programmable wait states), NREG general registers
// and a read-only STATUS holding the committed-write count.
module ahb_reg_slave #(
  parameter int          NREG     = 8,
  parameter logic [31:0] CTRL_RST = 32'h0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAITST, S_XFER, S_ERR1, S_ERR2} state_t;
  typedef enum logic [1:0] {T_CTRL, T_REG, T_STAT} tgt_t;

  state_t         r_state, w_next;
  logic [31:0]    r_regs [NREG];
  logic [31:0]    r_ctrl;
  logic [15:0]    r_cnt;
  logic [1:0]     r_wcnt;
  logic           r_write;
  logic [3:0]     r_be;
  tgt_t           r_tgt;
  logic [IW-1:0]  r_idx;

  logic [11:0]    w_a;
  logic [9:0]     w_woff;
  logic [9:0]     w_ridx;
  logic           w_is_ctrl, w_is_stat, w_is_reg, w_mis, w_bad, w_acc;
  logic [3:0]     w_be;
  logic [31:0]    w_rdata;
  logic           w_unused;

  assign w_unused = ^{HBURST, HPROT, HADDR[31:12], w_ridx};

  // Address-phase decode
  assign w_a       = HADDR[11:0];
  assign w_woff    = w_a[11:2];
  assign w_ridx    = w_woff - 10'h040;
  assign w_is_ctrl = (w_woff == 10'h00C);
  assign w_is_stat = (w_woff == 10'h080);
  assign w_is_reg  = (w_woff >= 10'h040) && (w_ridx < 10'(NREG));
  assign w_mis     = ((HSIZE == 3'b001) && w_a[0]) ||
                     ((HSIZE == 3'b010) && (w_a[1:0] != 2'b00));
  assign w_bad     = (HSIZE > 3'b010) || w_mis ||
                     !(w_is_ctrl || w_is_stat || w_is_reg) || (w_is_stat && HWRITE);
  assign w_acc     = HSEL && HREADY && HTRANS[1] && HREADYOUT;

  always_comb begin
    w_be = 4'b1111;
    case (HSIZE)
      3'b000:  w_be = 4'b0001 << w_a[1:0];
      3'b001:  w_be = w_a[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAITST: if (r_wcnt == 2'd0) w_next = S_XFER;
      S_ERR1:   w_next = S_ERR2;
      default: begin
        if (!w_acc)                 w_next = S_IDLE;
        else if (w_bad)             w_next = S_ERR1;
        else if (r_ctrl[1:0] != '0) w_next = S_WAITST;
        else                        w_next = S_XFER;
      end
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (r_tgt)
      T_CTRL:  w_rdata = r_ctrl;
      T_REG:   w_rdata = r_regs[r_idx];
      default: w_rdata = {16'h0000, r_cnt};
    endcase
  end

  assign HREADYOUT = !((r_state == S_WAITST) || (r_state == S_ERR1));
  assign HRESP     = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? 2'b01 : 2'b00;
  assign HRDATA    = ((r_state == S_XFER) && !r_write) ? w_rdata : '0;

  // A commit and a new accept can share an edge; the accept sees the pre-commit WAIT.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_ctrl  <= CTRL_RST;
      r_cnt   <= '0;
      r_wcnt  <= '0;
      r_write <= 1'b0;
      r_be    <= '0;
      r_tgt   <= T_CTRL;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_write <= HWRITE;
        r_be    <= w_be;
        r_tgt   <= w_is_ctrl ? T_CTRL : (w_is_reg ? T_REG : T_STAT);
        r_idx   <= w_ridx[IW-1:0];
      end
      if (w_acc && !w_bad && (r_ctrl[1:0] != '0))
        r_wcnt <= r_ctrl[1:0] - 2'd1;
      else if ((r_state == S_WAITST) && (r_wcnt != '0))
        r_wcnt <= r_wcnt - 2'd1;
      if ((r_state == S_XFER) && r_write) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (r_be[b]) begin
            if (r_tgt == T_CTRL) r_ctrl[8*b +: 8] <= HWDATA[8*b +: 8];
            else if (r_tgt == T_REG) r_regs[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
          end
        end
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_reg_slave.sv
// Randomized bench for ahb_reg_slave against a transaction-level register-map model.
module tb_ahb_reg_slave;

  localparam int          NREG = 4;
  localparam logic [31:0] CRST = 32'h0000_5A00;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HWRITE, HREADY, HREADYOUT;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_reg_slave #(.NREG(NREG), .CTRL_RST(CRST)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  typedef struct {
    bit        act;
    bit        sel;
    bit [1:0]  tr;
    bit [11:0] a;
    bit        wr;
    bit [2:0]  sz;
    bit [31:0] wd;
  } txn_t;

  int n_checks = 0;
  int n_errors = 0;

  bit [31:0] m_reg [NREG];
  bit [31:0] m_ctrl;
  bit [15:0] m_cnt;
  txn_t      cur;
  int        cur_wait;
  bit        cur_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic txn_t mk(bit [11:0] a, bit wr, bit [2:0] sz, bit [31:0] wd);
    txn_t t;
    t.act = 1'b0; t.sel = 1'b1; t.tr = 2'b10;
    t.a = a; t.wr = wr; t.sz = sz; t.wd = wd;
    return t;
  endfunction

  function automatic txn_t idle_t();
    txn_t t = mk(12'h000, 1'b0, 3'd2, 32'h0);
    t.tr = 2'b00;
    return t;
  endfunction

  function automatic bit is_bad(txn_t t);
    int off = int'({t.a[11:2], 2'b00});
    bit mapped = (off == 'h030) || (off == 'h200) || (off >= 'h100 && off < 'h100 + 4*NREG);
    if (t.sz > 3'd2) return 1'b1;
    if (t.sz == 3'd1 && t.a[0]) return 1'b1;
    if (t.sz == 3'd2 && t.a[1:0] != 2'b00) return 1'b1;
    if (!mapped) return 1'b1;
    return (off == 'h200) && t.wr;
  endfunction

  function automatic bit [31:0] m_read(bit [11:0] a);
    int off = int'({a[11:2], 2'b00});
    if (off == 'h030) return m_ctrl;
    if (off == 'h200) return {16'h0000, m_cnt};
    return m_reg[(off - 'h100) / 4];
  endfunction

  task automatic m_write(bit [11:0] a, bit [2:0] sz, bit [31:0] d);
    int off = int'({a[11:2], 2'b00});
    int nb = 1 << sz;
    bit [31:0] v = m_read(a);
    for (int k = 0; k < nb; k++) begin
      int lane = int'(a[1:0]) + k;
      v[8*lane +: 8] = d[8*lane +: 8];
    end
    if (off == 'h030) m_ctrl = v;
    else m_reg[(off - 'h100) / 4] = v;
    m_cnt++;
  endtask

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_ctrl = CRST;
    m_cnt = '0;
    cur = idle_t();
    cur_wait = 0;
    cur_bad = 1'b0;
  endtask

  // Called at a negedge: drives t's address phase, checks cur's data phase, ends one negedge after t is issued.
  task automatic step(input txn_t t);
    int        nw = 0;
    bit [1:0]  wresp = '0;
    bit        wrd = 1'b0;
    bit [31:0] exp_rd;
    int        new_wait;
    bit        new_bad, acc;
    HSEL = t.sel; HADDR = {20'($urandom()), t.a}; HTRANS = t.tr; HWRITE = t.wr;
    HSIZE = t.sz; HBURST = 3'($urandom()); HPROT = 4'($urandom()); HWDATA = cur.wd;
    for (int g = 0; g < 12 && !HREADYOUT; g++) begin
      nw++;
      wresp |= HRESP;
      wrd |= (HRDATA != '0);
      @(posedge HCLK); @(negedge HCLK);
    end
    exp_rd = (cur.act && !cur_bad && !cur.wr) ? m_read(cur.a) : '0;
    check("wait_cycles", nw, cur.act ? (cur_bad ? 1 : cur_wait) : 0);
    if (nw > 0) begin
      check("wait_resp", 32'(wresp), (cur.act && cur_bad) ? 1 : 0);
      check("wait_rdata", 32'(wrd), 0);
    end
    check("resp", 32'(HRESP), (cur.act && cur_bad) ? 1 : 0);
    check("rdata", HRDATA, exp_rd);
    acc = t.sel && t.tr[1];
    new_wait = int'(m_ctrl[1:0]);
    new_bad = is_bad(t);
    if (cur.act && !cur_bad && cur.wr) m_write(cur.a, cur.sz, cur.wd);
    @(posedge HCLK); @(negedge HCLK);
    cur = t;
    cur.act = acc;
    cur_wait = new_wait;
    cur_bad = new_bad;
  endtask

  function automatic txn_t rnd();
    txn_t     t = mk(12'h000, 1'($urandom()), 3'd2, $urandom());
    int       k = int'($urandom_range(0, 9));
    bit [1:0] lo = 2'($urandom());
    t.tr = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
    t.sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    if ($urandom_range(0, 7) != 0) begin
      if (t.sz == 3'd1) lo[0] = 1'b0;
      if (t.sz == 3'd2) lo = 2'b00;
    end
    case (k)
      0:       t.tr = 2'($urandom_range(0, 1));
      1:       t.sel = 1'b0;
      2:       t.a = {10'h00C, lo};
      3:       t.a = {10'h080, lo};
      4:       t.a = 12'($urandom());
      default: t.a = 12'('h100 + 4*$urandom_range(0, NREG)) | 12'(lo);
    endcase
    return t;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd2; HBURST = '0; HPROT = '0; HWDATA = '0;
    m_reset();
    repeat (3) @(negedge HCLK);
    check("rst_ready", 32'(HREADYOUT), 1);
    check("rst_resp", 32'(HRESP), 0);
    check("rst_rdata", HRDATA, 0);
    HRESET = 1'b0;

    step(mk(12'h030, 0, 2, 0)); step(mk(12'h200, 0, 2, 0));
    step(mk(12'h100, 0, 2, 0)); step(mk(12'h10C, 0, 2, 0));

    step(mk(12'h030, 1, 2, 32'h0000_0001)); step(idle_t());
    step(mk(12'h10C, 1, 2, 32'h0000_3078)); step(idle_t());
    step(mk(12'h10C, 0, 2, 0)); step(mk(12'h200, 0, 2, 0));

    step(mk(12'h030, 1, 2, 32'h0)); step(idle_t());
    step(mk(12'h100, 1, 2, 32'h3C00_1000)); step(mk(12'h104, 1, 2, 32'h3800_2000));
    step(mk(12'h100, 0, 2, 0)); step(mk(12'h104, 0, 2, 0));

    step(mk(12'h110, 1, 2, 32'hFFFF_FFFF)); step(mk(12'h200, 1, 2, 32'h1234_5678));
    step(mk(12'h200, 0, 2, 0)); step(mk(12'h110, 0, 2, 0));

    step(mk(12'h100, 1, 2, 32'h1122_3344)); step(mk(12'h102, 1, 0, 32'h00AA_0000));
    step(mk(12'h100, 1, 1, 32'h0000_BBCC)); step(mk(12'h100, 0, 2, 0));
    step(mk(12'h101, 0, 1, 0)); step(mk(12'h101, 1, 1, 32'hFFFF_FFFF));
    step(mk(12'h100, 0, 2, 0)); step(idle_t());

    n = 'hFFFF - int'(m_cnt);
    repeat (n) step(mk(12'h108, 1, 2, $urandom()));
    step(mk(12'h200, 0, 2, 0));
    step(mk(12'h10C, 1, 0, $urandom()));
    step(mk(12'h200, 0, 2, 0));
    step(mk(12'h200, 0, 1, 0));

    repeat (400) step(rnd());
    step(idle_t());

    step(mk(12'h030, 1, 2, 32'h0000_0003)); step(idle_t());
    step(mk(12'h104, 1, 2, 32'hDEAD_BEEF));
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = cur.wd;
    check("rst_wait1", 32'(HREADYOUT), 0);
    @(posedge HCLK); @(negedge HCLK);
    check("rst_wait2", 32'(HREADYOUT), 0);
    HRESET = 1'b1;
    @(posedge HCLK); @(negedge HCLK);
    HRESET = 1'b0;
    m_reset();
    check("mid_rst_ready", 32'(HREADYOUT), 1);
    check("mid_rst_resp", 32'(HRESP), 0);
    check("mid_rst_rdata", HRDATA, 0);
    step(mk(12'h104, 0, 2, 0)); step(mk(12'h200, 0, 2, 0));
    step(mk(12'h030, 0, 2, 0)); step(idle_t());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
